// File: rtl/vga_pkg.sv
// vga_pkg: default 640x480 VGA timing, RGB444 colours and pixel type
package vga_pkg;
   localparam int H_ACTIVE_DEFAULT = 640;
   localparam int H_FRONT_DEFAULT  = 16;
   localparam int H_SYNC_DEFAULT   = 96;
   localparam int H_BACK_DEFAULT   = 48;
   localparam int V_ACTIVE_DEFAULT = 480;
   localparam int V_FRONT_DEFAULT  = 10;
   localparam int V_SYNC_DEFAULT   = 2;
   localparam int V_BACK_DEFAULT   = 33;
   localparam int H_TOTAL_DEFAULT  = H_ACTIVE_DEFAULT + H_FRONT_DEFAULT + H_SYNC_DEFAULT + H_BACK_DEFAULT;
   localparam int V_TOTAL_DEFAULT  = V_ACTIVE_DEFAULT + V_FRONT_DEFAULT + V_SYNC_DEFAULT + V_BACK_DEFAULT;
   localparam logic [11:0] CELL_COLOR_DEFAULT = 12'hFD8;
   localparam logic [11:0] BG_COLOR_DEFAULT   = 12'h000;
   typedef struct packed {
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
   } pixel_rgb_t;
endpackage

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: tick-driven h/v counters with raw syncs, active flag and vblank
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int ACTIVE_COLUMNS = H_ACTIVE_DEFAULT,
   parameter int ACTIVE_ROWS    = V_ACTIVE_DEFAULT,
   parameter int H_FRONT        = H_FRONT_DEFAULT,
   parameter int H_SYNC         = H_SYNC_DEFAULT,
   parameter int H_BACK         = H_BACK_DEFAULT,
   parameter int V_FRONT        = V_FRONT_DEFAULT,
   parameter int V_SYNC         = V_SYNC_DEFAULT,
   parameter int V_BACK         = V_BACK_DEFAULT,
   parameter int H_W            = $clog2(ACTIVE_COLUMNS + H_FRONT + H_SYNC + H_BACK),
   parameter int V_W            = $clog2(ACTIVE_ROWS + V_FRONT + V_SYNC + V_BACK)
) (
   input  logic           clk_i,
   input  logic           reset_i,
   input  logic           pixel_tick_i,
   output logic [H_W-1:0] h_count,
   output logic [V_W-1:0] v_count,
   output logic           active,
   output logic           hsync_raw,
   output logic           vsync_raw,
   output logic           vblank,
   output logic           frame_end
);
   localparam int H_TOTAL = ACTIVE_COLUMNS + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = ACTIVE_ROWS + V_FRONT + V_SYNC + V_BACK;
   localparam logic [H_W-1:0] H_ACT   = H_W'(ACTIVE_COLUMNS);
   localparam logic [H_W-1:0] H_LAST  = H_W'(H_TOTAL - 1);
   localparam logic [H_W-1:0] HS_BEG  = H_W'(ACTIVE_COLUMNS + H_FRONT);
   localparam logic [H_W-1:0] HS_END  = H_W'(ACTIVE_COLUMNS + H_FRONT + H_SYNC - 1);
   localparam logic [V_W-1:0] V_ACT   = V_W'(ACTIVE_ROWS);
   localparam logic [V_W-1:0] V_LAST  = V_W'(V_TOTAL - 1);
   localparam logic [V_W-1:0] VS_BEG  = V_W'(ACTIVE_ROWS + V_FRONT);
   localparam logic [V_W-1:0] VS_END  = V_W'(ACTIVE_ROWS + V_FRONT + V_SYNC - 1);

   logic line_end;

   assign line_end  = h_count == H_LAST;
   assign frame_end = line_end && v_count == V_LAST;
   assign active    = h_count < H_ACT && v_count < V_ACT;
   assign hsync_raw = !(h_count >= HS_BEG && h_count <= HS_END);
   assign vsync_raw = !(v_count >= VS_BEG && v_count <= VS_END);
   assign vblank    = v_count >= V_ACT;

   // raster position advances one pixel per tick, wrapping at line and frame ends
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         h_count <= '0;
         v_count <= '0;
      end else if (pixel_tick_i) begin
         h_count <= line_end ? '0 : h_count + H_W'(1);
         if (line_end) v_count <= frame_end ? '0 : v_count + V_W'(1);
      end
   end
endmodule

// File: rtl/vram_display_reader.sv
// vram_display_reader: raster-order VRAM scan-out to registered VGA colour and syncs
module vram_display_reader
   import vga_pkg::*;
#(
   parameter int ACTIVE_COLUMNS   = H_ACTIVE_DEFAULT,
   parameter int ACTIVE_ROWS      = V_ACTIVE_DEFAULT,
   parameter int H_FRONT          = H_FRONT_DEFAULT,
   parameter int H_SYNC           = H_SYNC_DEFAULT,
   parameter int H_BACK           = H_BACK_DEFAULT,
   parameter int V_FRONT          = V_FRONT_DEFAULT,
   parameter int V_SYNC           = V_SYNC_DEFAULT,
   parameter int V_BACK           = V_BACK_DEFAULT,
   parameter int ADDR_WIDTH       = $clog2(ACTIVE_COLUMNS * ACTIVE_ROWS),
   parameter int DATA_WIDTH       = 1,
   parameter logic [11:0] CELL_COLOR = CELL_COLOR_DEFAULT,
   parameter logic [11:0] BG_COLOR   = BG_COLOR_DEFAULT
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  pixel_tick_i,
   input  logic [DATA_WIDTH-1:0] vram_read_data_i,
   output logic [ADDR_WIDTH-1:0] vram_read_address_o,
   output logic [3:0]            red_o,
   output logic [3:0]            green_o,
   output logic [3:0]            blue_o,
   output logic                  hsync_o,
   output logic                  vsync_o,
   output logic                  video_on_o,
   output logic                  vblank_o,
   output logic                  frame_done_o
);
   localparam int H_W = $clog2(ACTIVE_COLUMNS + H_FRONT + H_SYNC + H_BACK);
   localparam int V_W = $clog2(ACTIVE_ROWS + V_FRONT + V_SYNC + V_BACK);
   localparam logic [H_W-1:0] H_LAST_ACT = H_W'(ACTIVE_COLUMNS - 1);
   localparam logic [V_W-1:0] V_LAST_ACT = V_W'(ACTIVE_ROWS - 1);

   logic [H_W-1:0] h_count;
   logic [V_W-1:0] v_count;
   logic           active, hsync_raw, vsync_raw, frame_end;
   logic           first_pixel, last_pixel;
   logic           active_d, hsync_d, vsync_d;
   pixel_rgb_t     next_rgb, rgb_q;

   vga_timing_gen #(
      .ACTIVE_COLUMNS(ACTIVE_COLUMNS),
      .ACTIVE_ROWS   (ACTIVE_ROWS),
      .H_FRONT       (H_FRONT),
      .H_SYNC        (H_SYNC),
      .H_BACK        (H_BACK),
      .V_FRONT       (V_FRONT),
      .V_SYNC        (V_SYNC),
      .V_BACK        (V_BACK),
      .H_W           (H_W),
      .V_W           (V_W)
   ) u_timing (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .pixel_tick_i(pixel_tick_i),
      .h_count     (h_count),
      .v_count     (v_count),
      .active      (active),
      .hsync_raw   (hsync_raw),
      .vsync_raw   (vsync_raw),
      .vblank      (vblank_o),
      .frame_end   (frame_end)
   );

   assign first_pixel = h_count == '0 && v_count == '0;
   assign last_pixel  = h_count == H_LAST_ACT && v_count == V_LAST_ACT;
   assign red_o       = rgb_q.r;
   assign green_o     = rgb_q.g;
   assign blue_o      = rgb_q.b;

   // colour for the pixel whose address was issued on the previous tick
   always_comb begin
      next_rgb = !active_d ? pixel_rgb_t'(12'h000) :
                 (|vram_read_data_i) ? pixel_rgb_t'(CELL_COLOR) : pixel_rgb_t'(BG_COLOR);
   end

   // raster address counter: restarts at the first pixel, holds through blanking
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         vram_read_address_o <= '0;
         frame_done_o        <= 1'b0;
      end else begin
         frame_done_o <= pixel_tick_i && last_pixel;
         if (pixel_tick_i)
            vram_read_address_o <= active ? (first_pixel ? '0 : vram_read_address_o + ADDR_WIDTH'(1)) :
                                   frame_end ? '0 : vram_read_address_o;
      end
   end

   // one-tick delay of sync/active flags so they line up with the returned VRAM data
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         active_d   <= 1'b0;
         hsync_d    <= 1'b1;
         vsync_d    <= 1'b1;
         rgb_q      <= '0;
         video_on_o <= 1'b0;
         hsync_o    <= 1'b1;
         vsync_o    <= 1'b1;
      end else if (pixel_tick_i) begin
         active_d   <= active;
         hsync_d    <= hsync_raw;
         vsync_d    <= vsync_raw;
         rgb_q      <= next_rgb;
         video_on_o <= active_d;
         hsync_o    <= hsync_d;
         vsync_o    <= vsync_d;
      end
   end
endmodule

// File: tb/tb_vram_display_reader.sv
// tb_vram_display_reader: scoreboard bench against an independent raster model
module tb_vram_display_reader;
   localparam int AC = 64, AR = 48, HF = 8, HS = 16, HB = 8, VF = 3, VS = 2, VB = 4;
   localparam int HT = AC + HF + HS + HB;
   localparam int VT = AR + VF + VS + VB;
   localparam int AW = $clog2(AC * AR);
   localparam logic [11:0] CELL = 12'hFD8;
   localparam logic [11:0] BG   = 12'h135;

   typedef struct {
      logic [AW-1:0] a;
      logic [11:0]   rgb;
      logic          hs, vs, von, vb, fd;
   } exp_t;

   logic          clk = 1'b0;
   logic          reset_i = 1'b1;
   logic          pixel_tick_i = 1'b0;
   logic [0:0]    vram_read_data_i;
   logic [AW-1:0] vram_read_address_o;
   logic [3:0]    red_o, green_o, blue_o;
   logic          hsync_o, vsync_o, video_on_o, vblank_o, frame_done_o;

   int   n_checks = 0, n_fail = 0;
   int   n_fd = 0, n_vb = 0, n_vs = 0, n_hs = 0;
   exp_t sb[$];

   int            mh = 0, mv = 0;
   logic [AW-1:0] ea = '0;
   logic [11:0]   ergb = '0;
   logic          act_d = 0, hs_d = 1, vs_d = 1, evon = 0, ehs = 1, evs = 1, efd = 0;

   always #5 clk = ~clk;

   assign vram_read_data_i = vram_read_address_o[0];

   vram_display_reader #(
      .ACTIVE_COLUMNS(AC), .ACTIVE_ROWS(AR),
      .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
      .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
      .ADDR_WIDTH(AW), .DATA_WIDTH(1),
      .CELL_COLOR(CELL), .BG_COLOR(BG)
   ) dut (
      .clk_i              (clk),
      .reset_i            (reset_i),
      .pixel_tick_i       (pixel_tick_i),
      .vram_read_data_i   (vram_read_data_i),
      .vram_read_address_o(vram_read_address_o),
      .red_o              (red_o),
      .green_o            (green_o),
      .blue_o             (blue_o),
      .hsync_o            (hsync_o),
      .vsync_o            (vsync_o),
      .video_on_o         (video_on_o),
      .vblank_o           (vblank_o),
      .frame_done_o       (frame_done_o)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         if (n_fail <= 20) $display("FAIL %s at t=%0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   task automatic step(input bit t, input bit r);
      exp_t e;
      bit   act;
      pixel_tick_i = t;
      reset_i      = r;
      if (r) begin
         mh = 0; mv = 0; ea = '0; act_d = 0; hs_d = 1; vs_d = 1;
         ergb = '0; evon = 0; ehs = 1; evs = 1; efd = 0;
      end else if (t) begin
         act  = mh < AC && mv < AR;
         ergb = act_d ? (ea[0] ? CELL : BG) : 12'h000;
         evon = act_d; ehs = hs_d; evs = vs_d;
         act_d = act;
         hs_d  = !(mh >= AC + HF && mh < AC + HF + HS);
         vs_d  = !(mv >= AR + VF && mv < AR + VF + VS);
         efd   = mh == AC - 1 && mv == AR - 1;
         if (act) ea = AW'(mv * AC + mh);
         else if (mh == HT - 1 && mv == VT - 1) ea = '0;
         if (mh == HT - 1) begin
            mh = 0;
            mv = (mv == VT - 1) ? 0 : mv + 1;
         end else mh++;
      end else efd = 0;
      e = '{ea, ergb, ehs, evs, evon, mv >= AR, efd};
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk("addr",       32'(vram_read_address_o),         32'(e.a));
      chk("rgb",        32'({red_o, green_o, blue_o}),    32'(e.rgb));
      chk("hsync",      32'(hsync_o),                     32'(e.hs));
      chk("vsync",      32'(vsync_o),                     32'(e.vs));
      chk("video_on",   32'(video_on_o),                  32'(e.von));
      chk("vblank",     32'(vblank_o),                    32'(e.vb));
      chk("frame_done", 32'(frame_done_o),                32'(e.fd));
      if (frame_done_o) n_fd++;
      if (vblank_o) n_vb++;
      if (!vsync_o) n_vs++;
      if (t && !hsync_o) n_hs++;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      repeat (3) step(0, 1);
      chk("reset_hsync", 32'(hsync_o), 32'd1);
      chk("reset_addr",  32'(vram_read_address_o), 32'd0);
      n_fd = 0; n_vb = 0; n_vs = 0;
      repeat (HT * VT) step(1, 0);
      chk("frame_done_pulses", 32'(n_fd), 32'(1));
      chk("vblank_clks",       32'(n_vb), 32'((VT - AR) * HT));
      chk("vsync_low_clks",    32'(n_vs), 32'(VS * HT));
      chk("addr_after_wrap",   32'(vram_read_address_o), 32'd0);
      n_hs = 0;
      repeat (2 * HT) begin
         step(1, 0);
         repeat (3) step(0, 0);
      end
      chk("hsync_low_ticks", 32'(n_hs), 32'(2 * HS));
      repeat (HT / 3) step(1, 0);
      repeat (1000) step(0, 0);
      repeat (HT) step(1, 0);
      for (int i = 0; i < HT * VT && !(mh == 30 && mv == 20); i++) step(1, 0);
      step(1, 1);
      chk("midframe_reset_addr",  32'(vram_read_address_o), 32'd0);
      chk("midframe_reset_hsync", 32'(hsync_o), 32'd1);
      chk("midframe_reset_rgb",   32'({red_o, green_o, blue_o}), 32'd0);
      repeat (HT * VT + HT) step(1, 0);
      repeat (4000) step(1'($urandom_range(0, 1)), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
